// File: rtl/pcs_pkg.sv
// ============================================================================
// Module : pcs_pkg
// Brief  : Shared constants and lock-FSM state type for the 10GBASE-R RX PCS.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pcs_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;
  localparam int         BLOCK_W = 66;
  localparam int         BUF_W   = 2 * BLOCK_W - 2;

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    RESET_CNT = 2'd1,
    TEST_SH   = 2'd2,
    SLIP      = 2'd3
  } lock_state_t;

  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_gearbox_64_66.sv
// ============================================================================
// Module : rx_gearbox_64_66
// Brief  : 64-bit to 66-bit RX gearbox with single-bit slip for block alignment.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_gearbox_64_66
  import pcs_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [63:0]        i_rxd,
  input  logic               i_rxd_valid,
  input  logic               i_slip,
  output logic [BLOCK_W-1:0] o_block,
  output logic               o_valid,
  output logic               o_slipped
);

  logic [BUF_W-1:0]   r_buf;
  logic [7:0]         r_fill;
  logic               r_slip_pend;
  logic [BLOCK_W-1:0] r_block;
  logic               r_valid;
  logic               r_slipped;

  logic [BUF_W-1:0]   w_buf_app;
  logic [BUF_W-1:0]   w_buf_nxt;
  logic [7:0]         w_fill_app;
  logic [7:0]         w_fill_nxt;
  logic               w_slip_pend_nxt;
  logic               w_emit;
  logic               w_do_slip;

  // Fill never exceeds 65 before an append, so the appended word always fits.
  always_comb begin
    w_buf_app       = r_buf | ({{(BUF_W-64){1'b0}}, i_rxd} << r_fill);
    w_fill_app      = r_fill + 8'd64;
    w_emit          = i_rxd_valid && (w_fill_app >= 8'd66);
    w_do_slip       = w_emit && r_slip_pend && (w_fill_app >= 8'd67);
    w_buf_nxt       = r_buf;
    w_fill_nxt      = r_fill;
    w_slip_pend_nxt = r_slip_pend | i_slip;
    if (i_rxd_valid) begin
      w_buf_nxt  = w_buf_app;
      w_fill_nxt = w_fill_app;
    end
    if (w_do_slip) begin
      w_buf_nxt       = w_buf_app >> 67;
      w_fill_nxt      = w_fill_app - 8'd67;
      w_slip_pend_nxt = i_slip;
    end else if (w_emit) begin
      w_buf_nxt  = w_buf_app >> 66;
      w_fill_nxt = w_fill_app - 8'd66;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_buf       <= '0;
      r_fill      <= '0;
      r_slip_pend <= 1'b0;
      r_block     <= '0;
      r_valid     <= 1'b0;
      r_slipped   <= 1'b0;
    end else begin
      r_buf       <= w_buf_nxt;
      r_fill      <= w_fill_nxt;
      r_slip_pend <= w_slip_pend_nxt;
      r_valid     <= w_emit;
      r_slipped   <= w_do_slip;
      if (w_emit) begin
        r_block <= w_do_slip ? w_buf_app[66:1] : w_buf_app[65:0];
      end
    end
  end

  assign o_block   = r_block;
  assign o_valid   = r_valid;
  assign o_slipped = r_slipped;

endmodule

`default_nettype wire

// File: rtl/pcs_rx_block_sync.sv
// ============================================================================
// Module : pcs_rx_block_sync
// Brief  : 10GBASE-R RX gearbox plus sync-header block lock state machine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pcs_rx_block_sync
  import pcs_pkg::*;
#(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [63:0] i_rxd,
  input  logic        i_rxd_valid,
  output logic [1:0]  o_header,
  output logic [63:0] o_data,
  output logic        o_valid,
  output logic        o_block_lock,
  output logic        o_header_err
);

  localparam int CNT_W = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W = $clog2(SH_INVALID_MAX + 1);

  logic [BLOCK_W-1:0] w_block;
  logic               w_valid;
  logic               w_slipped;
  logic               w_slip;
  logic               w_sh_valid;

  lock_state_t        r_state;
  lock_state_t        w_state_nxt;
  logic [CNT_W-1:0]   r_sh_cnt;
  logic [CNT_W-1:0]   w_sh_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_base;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [INV_W-1:0]   r_sh_inv;
  logic [INV_W-1:0]   w_sh_inv_nxt;
  logic [INV_W-1:0]   w_inv_base;
  logic [INV_W-1:0]   w_inv_inc;
  logic               r_block_lock;
  logic               w_block_lock_nxt;

  rx_gearbox_64_66 u_gearbox (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_rxd       (i_rxd),
    .i_rxd_valid (i_rxd_valid),
    .i_slip      (w_slip),
    .o_block     (w_block),
    .o_valid     (w_valid),
    .o_slipped   (w_slipped)
  );

  assign w_sh_valid = sh_is_valid(w_block[1:0]);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= LOCK_INIT;
      r_sh_cnt     <= '0;
      r_sh_inv     <= '0;
      r_block_lock <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sh_cnt     <= w_sh_cnt_nxt;
      r_sh_inv     <= w_sh_inv_nxt;
      r_block_lock <= w_block_lock_nxt;
    end
  end

  // RESET_CNT clears the counters and still counts a block arriving that cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_sh_cnt_nxt     = r_sh_cnt;
    w_sh_inv_nxt     = r_sh_inv;
    w_block_lock_nxt = r_block_lock;
    w_slip           = 1'b0;
    w_cnt_base       = (r_state == RESET_CNT) ? '0 : r_sh_cnt;
    w_inv_base       = (r_state == RESET_CNT) ? '0 : r_sh_inv;
    w_cnt_inc        = w_cnt_base + CNT_W'(1);
    w_inv_inc        = w_inv_base + {{(INV_W-1){1'b0}}, ~w_sh_valid};
    case (r_state)
      LOCK_INIT: begin
        w_block_lock_nxt = 1'b0;
        w_state_nxt      = RESET_CNT;
      end
      RESET_CNT, TEST_SH: begin
        w_sh_cnt_nxt = w_cnt_base;
        w_sh_inv_nxt = w_inv_base;
        w_state_nxt  = TEST_SH;
        if (w_valid) begin
          w_sh_cnt_nxt = w_cnt_inc;
          w_sh_inv_nxt = w_inv_inc;
          // Loss of lock wins over a window end on the same block.
          if (!w_sh_valid && (w_inv_inc == INV_W'(SH_INVALID_MAX))) begin
            w_block_lock_nxt = 1'b0;
            w_state_nxt      = SLIP;
            w_slip           = 1'b1;
          end else if (!w_sh_valid && !r_block_lock) begin
            w_state_nxt = SLIP;
            w_slip      = 1'b1;
          end else if (w_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
            if (w_inv_inc == '0) begin
              w_block_lock_nxt = 1'b1;
            end
            w_state_nxt = RESET_CNT;
          end
        end
      end
      SLIP: begin
        if (w_valid && w_slipped) begin
          w_state_nxt = RESET_CNT;
        end
      end
      default: begin
        w_state_nxt = LOCK_INIT;
      end
    endcase
  end

  assign o_header     = w_block[1:0];
  assign o_data       = w_block[65:2];
  assign o_valid      = w_valid;
  assign o_block_lock = r_block_lock;
  assign o_header_err = w_valid & ~w_sh_valid;

endmodule

`default_nettype wire
